axi_sd_dma_master: RTL and testbench

AXI_SD_DMA_MASTER -- requirements
Module: axi_sd_dma_master

---
 rtl/axi_sd_pkg.sv | 55 +++++
 rtl/axi_sd_dma_master.sv | 169 ++++++++++++++++
 tb/tb_axi_sd_dma_master.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sd_pkg.sv
// axi_sd_pkg -- shared definitions for the SD-card DMA AXI4 master.
//   state_e        : controller states (IDLE, AR, R, AW, W, B)
//   AXI_*          : AXI4 burst type, transfer size and response codes
//   beats_to_4k()  : beats allowed before the next 4 KB page boundary
//   resp_is_err()  : true for SLVERR / DECERR responses
package axi_sd_pkg;

  // Raw state codes kept as plain constants so older code that compares
  // against 3-bit values keeps working; the enum reuses the same codes.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = S_IDLE,
    ST_AR   = S_AR,
    ST_R    = S_R,
    ST_AW   = S_AW,
    ST_W    = S_W,
    ST_B    = S_B
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // word_off is the word index inside the current 4 KB page (1024 words).
  // Result is min(max_beats, words left in the page), always 1..256.
  function automatic logic [8:0] beats_to_4k(input logic [9:0] word_off,
                                             input logic [8:0] max_beats);
    logic [10:0] room;
    room = 11'd1024 - {1'b0, word_off};
    if (room < {2'b00, max_beats})
      beats_to_4k = room[8:0];
    else
      beats_to_4k = max_beats;
  endfunction

  function automatic logic resp_is_err(input logic [1:0] resp);
    case (resp)
      AXI_RESP_OKAY:   resp_is_err = 1'b0;
      AXI_RESP_EXOKAY: resp_is_err = 1'b0;
      AXI_RESP_SLVERR: resp_is_err = 1'b1;
      AXI_RESP_DECERR: resp_is_err = 1'b1;
      default:         resp_is_err = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/axi_sd_dma_master.sv
// axi_sd_dma_master -- turns the SD FIFO filler's word-beat requests into
// AXI4 INCR bursts (32-bit beats), never crossing a 4 KB page.
//
// Parameter:
//   burst_len    max beats per burst (power of two, 1..256)
// Optional feature (compile-time macro AXI_SD_DMA_ERR_EN):
//   defined   -> err_o is a sticky flag set by SLVERR/DECERR on B or R
//   undefined -> err_o tied 0, bresp/rresp ignored
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   adr_i[29:0]            word address (byte address [31:2])
//   dat_i / dat_o          write data in / read data out
//   we_i, stb_i            direction (1=write) and request
//   ack_o, last_o          beat accepted / final beat of the burst
//   aw*, w*, b*            AXI4 write address, data and response channels
//   ar*, r*                AXI4 read address and data channels
//   err_o                  sticky bus error
module axi_sd_dma_master #(
  parameter int unsigned burst_len = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic        last_o,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        err_o
);
  import axi_sd_pkg::*;

  localparam logic [8:0] BURST_BEATS = 9'(burst_len);

  state_e      r_state;
  logic [29:0] r_adr;
  logic [7:0]  r_len;     // N-1 of the burst in flight
  logic [7:0]  r_cnt;     // beats acknowledged so far
  logic [8:0]  w_beats;
  logic        w_in_r;
  logic        w_in_w;
  logic        w_at_last;

  assign w_beats   = beats_to_4k(adr_i[9:0], BURST_BEATS);
  assign w_in_r    = (r_state == ST_R);
  assign w_in_w    = (r_state == ST_W);
  // The slave's rlast is not trusted; the local count decides the last beat.
  assign w_at_last = (r_cnt == r_len);

  // Address channels: both carry the latched burst, only one is ever valid.
  assign araddr  = {r_adr, 2'b00};
  assign awaddr  = {r_adr, 2'b00};
  assign arlen   = r_len;
  assign awlen   = r_len;
  assign arsize  = AXI_SIZE_4B;
  assign awsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;
  assign awburst = AXI_BURST_INCR;
  assign arvalid = (r_state == ST_AR);
  assign awvalid = (r_state == ST_AW);

  // Data channels follow stb_i directly so a paused filler simply stalls
  // the burst instead of aborting it.
  assign rready = w_in_r & stb_i & ~we_i;
  assign wvalid = w_in_w & stb_i & we_i;
  assign wdata  = dat_i;
  assign wstrb  = 4'hF;
  assign wlast  = w_in_w & w_at_last;
  assign bready = (r_state == ST_B);
  assign dat_o  = rdata;

  assign ack_o  = (rvalid & rready) | (wvalid & wready);
  assign last_o = (w_in_r | w_in_w) & w_at_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_adr   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (stb_i) begin
            r_adr   <= adr_i;
            r_len   <= 8'(w_beats - 9'd1);
            r_state <= we_i ? ST_AW : ST_AR;
          end
        end
        ST_AR: begin
          if (arready) begin
            r_cnt   <= '0;
            r_state <= ST_R;
          end
        end
        ST_AW: begin
          if (awready) begin
            r_cnt   <= '0;
            r_state <= ST_W;
          end
        end
        ST_R: begin
          if (ack_o) begin
            r_cnt <= r_cnt + 8'd1;
            if (w_at_last) r_state <= ST_IDLE;
          end
        end
        ST_W: begin
          if (ack_o) begin
            r_cnt <= r_cnt + 8'd1;
            if (w_at_last) r_state <= ST_B;
          end
        end
        ST_B: begin
          if (bvalid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef AXI_SD_DMA_ERR_EN
  logic r_err;
  logic w_unused;

  always_ff @(posedge clock) begin
    if (reset)
      r_err <= 1'b0;
    else if ((bvalid & bready & resp_is_err(bresp)) |
             (rvalid & rready & resp_is_err(rresp)))
      r_err <= 1'b1;
  end

  assign err_o    = r_err;
  assign w_unused = rlast;
`else
  logic w_unused;

  assign err_o    = 1'b0;
  assign w_unused = ^{rlast, bresp, rresp};
`endif

endmodule

// File: tb/tb_axi_sd_dma_master.sv
`timescale 1ns/1ps
module tb_axi_sd_dma_master;
  localparam int BL = 16;
`ifdef AXI_SD_DMA_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif
  localparam int P_IDLE = 0, P_AR = 1, P_AW = 2, P_RD = 3, P_WR = 4, P_B = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        we_i = 1'b0, stb_i = 1'b0, ack_o, last_o;
  logic [31:0] awaddr, wdata, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awvalid, wlast, wvalid, bready, arvalid, rready, err_o;
  logic [3:0]  wstrb;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic        arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  axi_sd_dma_master #(.burst_len(BL)) dut (
    .clock(clock), .reset(reset), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .we_i(we_i), .stb_i(stb_i), .ack_o(ack_o), .last_o(last_o),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_o(err_o)
  );

  initial forever #5 clock = ~clock;

  int n_vec = 0, n_fail = 0;

  // stimulus control (written by the main sequence)
  int          req_id = 0;
  logic        cfg_we = 1'b0, cfg_wtoggle = 1'b0, cfg_bad_rlast = 1'b0;
  logic [29:0] cfg_adr = '0;
  logic [1:0]  cfg_bresp = 2'b00;
  int          stall_at = -1, stall_len = 0;
  logic        chk_en = 1'b0;

  // filler progress (written by the compare process)
  int done_id = 0, fill_idx = 0, cmp_seen = 0, cyc = 0;

  // behavioural model of the master
  int          m_phase = P_IDLE, m_n = 0, m_beats = 0;
  logic [29:0] m_addr = '0;
  logic        m_err = 1'b0;

  // AXI slave memory model
  logic [31:0] s_raddr = '0;
  int          s_rleft = 0, s_rk = 0;
  logic        s_bpend = 1'b0;

  // per-request statistics
  int          st_acks, st_lasts, st_last_idx, st_rlow, st_first_ack, st_last_ack, st_bhs;
  logic [31:0] st_ar_addr, st_aw_addr;
  logic [7:0]  st_ar_len, st_aw_len;
  logic [31:0] rq[$];
  logic [31:0] wq[$];

  function automatic logic [31:0] rpat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] wpat(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic compare_loop();
    logic e_rr, e_wv, e_ack, e_last, e_err;
    int room;
    forever begin
      @(negedge clock);
      cyc++;
      if (req_id != cmp_seen) begin
        cmp_seen = req_id;
        st_acks = 0; st_lasts = 0; st_last_idx = -1; st_rlow = 0;
        st_first_ack = 0; st_last_ack = 0; st_bhs = 0;
        st_ar_addr = '0; st_aw_addr = '0; st_ar_len = '0; st_aw_len = '0;
        rq.delete(); wq.delete();
      end
      // expected outputs from the model
      e_rr   = (m_phase == P_RD) && stb_i && !we_i;
      e_wv   = (m_phase == P_WR) && stb_i && we_i;
      e_ack  = (e_rr && rvalid) || (e_wv && wready);
      e_last = ((m_phase == P_RD) || (m_phase == P_WR)) && (m_beats == m_n - 1);
      e_err  = EXP_ERR & m_err;
      if (chk_en) begin
        chk1("arvalid", arvalid, m_phase == P_AR);
        chk1("awvalid", awvalid, m_phase == P_AW);
        chk1("rready", rready, e_rr);
        chk1("wvalid", wvalid, e_wv);
        chk1("bready", bready, m_phase == P_B);
        chk1("ack_o", ack_o, e_ack);
        chk1("last_o", last_o, e_last);
        chk1("err_o", err_o, e_err);
        if (m_phase == P_AR) begin
          chk("araddr", araddr, {m_addr, 2'b00});
          chk("arlen", 32'(arlen), 32'(m_n - 1));
          chk("arsize", 32'(arsize), 32'd2);
          chk("arburst", 32'(arburst), 32'd1);
        end
        if (m_phase == P_AW) begin
          chk("awaddr", awaddr, {m_addr, 2'b00});
          chk("awlen", 32'(awlen), 32'(m_n - 1));
          chk("awsize", 32'(awsize), 32'd2);
          chk("awburst", 32'(awburst), 32'd1);
        end
        if (e_wv) begin
          chk("wdata", wdata, wpat(m_beats));
          chk("wstrb", 32'(wstrb), 32'hF);
          chk1("wlast", wlast, e_last);
        end
        if (e_ack && m_phase == P_RD)
          chk("dat_o", dat_o, rpat({m_addr, 2'b00} + 32'(4 * m_beats)));
      end
      // filler-side statistics, taken from what the DUT shows
      if (ack_o) begin
        if (st_acks == 0) st_first_ack = cyc;
        st_last_ack = cyc;
        if (last_o) begin st_lasts++; st_last_idx = st_acks; end
        if (!we_i) rq.push_back(dat_o);
        st_acks++;
      end
      if (m_phase == P_RD && !rready) st_rlow++;
      if (arvalid && arready) begin st_ar_addr = araddr; st_ar_len = arlen; end
      if (awvalid && awready) begin st_aw_addr = awaddr; st_aw_len = awlen; end
      if (wvalid && wready) wq.push_back(wdata);
      if (bvalid && bready) st_bhs++;
      // filler progress
      if (reset) begin
        done_id = req_id; fill_idx = 0;
      end else if (ack_o) begin
        if (last_o) begin done_id = req_id; fill_idx = 0; end
        else fill_idx++;
      end
      // model next state
      if (reset) begin
        m_phase = P_IDLE; m_beats = 0; m_err = 1'b0;
      end else begin
        case (m_phase)
          P_IDLE: if (stb_i) begin
            m_addr  = adr_i;
            room    = 1024 - int'(adr_i[9:0]);
            m_n     = (BL < room) ? BL : room;
            m_phase = we_i ? P_AW : P_AR;
          end
          P_AR: if (arready) begin m_phase = P_RD; m_beats = 0; end
          P_AW: if (awready) begin m_phase = P_WR; m_beats = 0; end
          P_RD: if (e_ack) begin
            if (rresp[1]) m_err = 1'b1;
            if (m_beats == m_n - 1) m_phase = P_IDLE;
            m_beats++;
          end
          P_WR: if (e_ack) begin
            if (m_beats == m_n - 1) m_phase = P_B;
            m_beats++;
          end
          P_B: if (bvalid) begin
            if (bresp[1]) m_err = 1'b1;
            m_phase = P_IDLE;
          end
          default: m_phase = P_IDLE;
        endcase
      end
      // slave memory model
      if (reset) begin
        s_rleft = 0; s_rk = 0; s_bpend = 1'b0;
      end else begin
        if (arvalid && arready) begin
          s_raddr = araddr; s_rleft = int'(arlen) + 1; s_rk = 0;
        end else if (rvalid && rready) begin
          s_rk++; s_rleft--;
        end
        if (wvalid && wready && wlast) s_bpend = 1'b1;
        if (bvalid && bready) s_bpend = 1'b0;
      end
    end
  endtask

  task automatic drive_loop();
    logic tog = 1'b0;
    int   seen = 0, used = 0;
    logic act, s;
    forever begin
      @(posedge clock);
      #1;
      tog = ~tog;
      if (req_id != seen) begin seen = req_id; used = 0; end
      act = (req_id != done_id);
      s   = act;
      if (act && fill_idx == stall_at && used < stall_len) begin s = 1'b0; used++; end
      stb_i   = s;
      we_i    = cfg_we;
      adr_i   = cfg_adr;
      dat_i   = wpat(fill_idx);
      arready = tog;
      awready = ~tog;
      rvalid  = (s_rleft > 0);
      rdata   = rpat(s_raddr + 32'(4 * s_rk));
      rlast   = cfg_bad_rlast ? (s_rk == 0) : (s_rleft == 1);
      rresp   = 2'b00;
      wready  = cfg_wtoggle ? tog : 1'b1;
      bvalid  = s_bpend;
      bresp   = cfg_bresp;
    end
  endtask

  task automatic start_req(input logic we, input logic [29:0] adr);
    cfg_we = we; cfg_adr = adr; req_id++;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (!(done_id == req_id && m_phase == P_IDLE) && n < budget) begin
      @(posedge clock); #2; n++;
    end
    chk1({nm, "_completed"}, (done_id == req_id) && (m_phase == P_IDLE), 1'b1);
    @(posedge clock); #2;
  endtask

  initial begin
    fork
      compare_loop();
      drive_loop();
    join_none
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    chk_en = 1'b1;
    chk1("rst_arvalid", arvalid, 1'b0);
    chk1("rst_awvalid", awvalid, 1'b0);
    chk1("rst_wvalid", wvalid, 1'b0);
    chk1("rst_bready", bready, 1'b0);
    chk1("rst_rready", rready, 1'b0);
    chk1("rst_ack", ack_o, 1'b0);
    chk1("rst_last", last_o, 1'b0);
    chk1("rst_err", err_o, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;

    // full 16-beat read at word 0x100
    start_req(1'b0, 30'h100);
    wait_idle("rd16", 300);
    chk("rd16_araddr", st_ar_addr, 32'h0000_0400);
    chk("rd16_arlen", 32'(st_ar_len), 32'd15);
    chk("rd16_acks", 32'(st_acks), 32'd16);
    chk("rd16_lasts", 32'(st_lasts), 32'd1);
    chk("rd16_last_idx", 32'(st_last_idx), 32'd15);
    if (rq.size() > 0) chk("rd16_first_data", rq[0], 32'h5A5A_0400);
    for (int k = 0; k < rq.size(); k++) chk("rd16_order", rq[k], rpat(32'h400 + 32'(4 * k)));
    $display("txn rd16: araddr=%08h arlen=%0d acks=%0d", st_ar_addr, st_ar_len, st_acks);

    // write two words below a 4 KB boundary
    start_req(1'b1, 30'h3FE);
    wait_idle("wr2", 300);
    chk("wr2_awaddr", st_aw_addr, 32'h0000_0FF8);
    chk("wr2_awlen", 32'(st_aw_len), 32'd1);
    chk("wr2_acks", 32'(st_acks), 32'd2);
    chk("wr2_last_idx", 32'(st_last_idx), 32'd1);
    chk("wr2_bhs", 32'(st_bhs), 32'd1);
    chk("wr2_wq", 32'(wq.size()), 32'd2);
    for (int k = 0; k < wq.size(); k++) chk("wr2_order", wq[k], wpat(k));
    $display("txn wr2: awaddr=%08h awlen=%0d acks=%0d b=%0d", st_aw_addr, st_aw_len, st_acks, st_bhs);

    // write with wready toggling every cycle
    cfg_wtoggle = 1'b1;
    start_req(1'b1, 30'h200);
    wait_idle("wrtog", 400);
    cfg_wtoggle = 1'b0;
    chk("wrtog_awlen", 32'(st_aw_len), 32'd15);
    chk("wrtog_acks", 32'(st_acks), 32'd16);
    chk("wrtog_span", 32'(st_last_ack - st_first_ack), 32'd30);
    chk("wrtog_wq", 32'(wq.size()), 32'd16);
    for (int k = 0; k < wq.size(); k++) chk("wrtog_order", wq[k], wpat(k));
    $display("txn wrtog: acks=%0d span=%0d", st_acks, st_last_ack - st_first_ack);

    // read with stb_i dropped for 5 cycles after beat 5
    stall_at = 5; stall_len = 5;
    start_req(1'b0, 30'h40);
    wait_idle("rdstall", 400);
    stall_at = -1; stall_len = 0;
    chk("rdstall_rlow", 32'(st_rlow), 32'd5);
    chk("rdstall_acks", 32'(st_acks), 32'd16);
    chk("rdstall_rq", 32'(rq.size()), 32'd16);
    for (int k = 0; k < rq.size(); k++) chk("rdstall_order", rq[k], rpat(32'h100 + 32'(4 * k)));
    $display("txn rdstall: rready_low=%0d acks=%0d", st_rlow, st_acks);

    // short read with a slave that asserts rlast on the wrong beat
    cfg_bad_rlast = 1'b1;
    start_req(1'b0, 30'h3FC);
    wait_idle("rdbad", 300);
    cfg_bad_rlast = 1'b0;
    chk("rdbad_araddr", st_ar_addr, 32'h0000_0FF0);
    chk("rdbad_arlen", 32'(st_ar_len), 32'd3);
    chk("rdbad_acks", 32'(st_acks), 32'd4);
    chk("rdbad_last_idx", 32'(st_last_idx), 32'd3);
    $display("txn rdbad: arlen=%0d acks=%0d last_idx=%0d", st_ar_len, st_acks, st_last_idx);

    // write answered with SLVERR
    cfg_bresp = 2'b10;
    start_req(1'b1, 30'h10);
    wait_idle("wrerr", 300);
    cfg_bresp = 2'b00;
    chk1("wrerr_err", err_o, EXP_ERR);
    start_req(1'b0, 30'h20);
    wait_idle("rdafter", 300);
    chk1("err_sticky", err_o, EXP_ERR);
    $display("txn wrerr: err_o=%0b", err_o);

    // reset during beat 4 of a write
    start_req(1'b1, 30'h0);
    begin
      int n = 0;
      while (!(fill_idx == 3 && m_phase == P_WR) && n < 200) begin
        @(posedge clock); #2; n++;
      end
      chk1("rstmid_reached_beat4", (fill_idx == 3) && (m_phase == P_WR), 1'b1);
    end
    reset = 1'b1;
    @(posedge clock);
    #2;
    chk1("rstmid_awvalid", awvalid, 1'b0);
    chk1("rstmid_wvalid", wvalid, 1'b0);
    chk1("rstmid_arvalid", arvalid, 1'b0);
    chk1("rstmid_bready", bready, 1'b0);
    chk1("rstmid_ack", ack_o, 1'b0);
    chk1("rstmid_err", err_o, 1'b0);
    reset = 1'b0;
    $display("txn rstmid: valids cleared, acked=%0d", st_acks);
    repeat (2) @(posedge clock);
    #2;

    // recovery: single-word read at the last word of a page
    start_req(1'b0, 30'h3FF);
    wait_idle("rd1", 200);
    chk("rd1_arlen", 32'(st_ar_len), 32'd0);
    chk("rd1_acks", 32'(st_acks), 32'd1);
    chk("rd1_lasts", 32'(st_lasts), 32'd1);
    $display("txn rd1: arlen=%0d acks=%0d", st_ar_len, st_acks);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
